wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// (MEM/WB writeback) and a multi-cycle mult/div unit. The pipeline always has
// priority. MDU results that cannot be written immediately are parked in a
// 2-entry FIFO and drained on cycles when the pipeline does not write. If the
// FIFO head has waited STARVE_MAX cycles, a registered stall request asks the
// pipeline to insert a bubble so the head can drain.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   pipe_we/waddr/wdata       pipeline writeback request
//   mdu_valid/addr/data       MDU result offer (held until accepted)
//   mdu_ready                 arbiter can accept an MDU result this cycle
//   rf_we/waddr/wdata         registered register-file write port
//   rf_src                    source of the current write (0 pipe, 1 mdu)
//   stall_pipe                registered bubble request for MEM/WB
//   pend_cnt                  FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_src,
    output logic        stall_pipe,
    output logic [1:0]  pend_cnt
);

    localparam int AGE_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

    logic [4:0]       fifo_addr [2];
    logic [31:0]      fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic [AGE_W-1:0] age;

    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        pop;
    logic        bypass;
    logic        push;
    logic        grant;
    logic [4:0]  grant_addr;
    logic [31:0] grant_data;
    logic        grant_src;

    assign fifo_empty = (cnt == 2'd0);
    assign fifo_full  = (cnt == 2'd2);
    // Gated by rst directly so the source never sees a handshake during reset.
    assign mdu_ready  = !rst && !fifo_full;
    assign accept     = mdu_valid && mdu_ready;
    assign pop        = !pipe_we && !fifo_empty;
    // An accepted result skips the FIFO only when nothing older is waiting.
    assign bypass     = !pipe_we && fifo_empty && accept;
    assign push       = accept && !bypass;
    assign pend_cnt   = cnt;

    always_comb begin
        grant      = 1'b0;
        grant_addr = 5'd0;
        grant_data = 32'd0;
        grant_src  = 1'b0;
        if (pipe_we) begin
            grant      = 1'b1;
            grant_addr = pipe_waddr;
            grant_data = pipe_wdata;
        end else if (pop) begin
            grant      = 1'b1;
            grant_addr = fifo_addr[rd_ptr];
            grant_data = fifo_data[rd_ptr];
            grant_src  = 1'b1;
        end else if (bypass) begin
            grant      = 1'b1;
            grant_addr = mdu_addr;
            grant_data = mdu_data;
            grant_src  = 1'b1;
        end
    end

    // FIFO storage carries no reset; validity is tracked by cnt/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= mdu_addr;
            fifo_data[wr_ptr] <= mdu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (push && !pop)      cnt <= cnt + 2'd1;
            else if (pop && !push) cnt <= cnt - 2'd1;
        end
    end

    // Age of the FIFO head; stall is raised the cycle after it saturates and
    // dropped as soon as the head drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age        <= '0;
            stall_pipe <= 1'b0;
        end else begin
            stall_pipe <= (age == AGE_MAX) && !pop;
            if (fifo_empty || pop)  age <= '0;
            else if (age != AGE_MAX) age <= age + 1'b1;
        end
    end

    // Register zero is never written, but the grant still consumes its slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
            rf_src   <= 1'b0;
        end else begin
            rf_we <= grant && (grant_addr != 5'd0);
            if (grant) begin
                rf_waddr <= grant_addr;
                rf_wdata <= grant_data;
                rf_src   <= grant_src;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int SM = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_src;
    logic        stall_pipe;
    logic [1:0]  pend_cnt;

    wb_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_src(rf_src),
        .stall_pipe(stall_pipe), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    // Reference model: a queue of waiting results plus the head's wait time.
    ent_t        q[$];
    int          head_wait;
    bit          m_stall;
    bit          e_we, e_src, e_known;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    bit          last_acc;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic model_reset();
        q.delete();
        head_wait = 0;
        m_stall   = 0;
        e_we      = 0;
        e_src     = 0;
        e_known   = 1;
        e_waddr   = 0;
        e_wdata   = 0;
    endtask

    task automatic check_outputs();
        chk("rf_we", rf_we, e_we);
        if (e_we) chk("rf_src", rf_src, e_src);
        if (e_known) begin
            chk("rf_waddr", rf_waddr, e_waddr);
            chk("rf_wdata", rf_wdata, e_wdata);
        end
        chk("pend_cnt", pend_cnt, q.size());
        chk("stall_pipe", stall_pipe, m_stall);
        chk("mdu_ready", mdu_ready, q.size() != 2);
    endtask

    // Called at a falling edge with inputs already applied: checks outputs,
    // advances the model across the next rising edge, returns at the next
    // falling edge.
    task automatic cycle();
        bit          acc, gnt, gsrc, popped, was_empty;
        logic [4:0]  ga;
        logic [31:0] gd;
        ent_t        h;
        check_outputs();
        acc = mdu_valid && (q.size() != 2);
        was_empty = (q.size() == 0);
        gnt = 0; gsrc = 0; popped = 0; ga = 0; gd = 0;
        if (pipe_we) begin
            gnt = 1; ga = pipe_waddr; gd = pipe_wdata;
        end else if (q.size() > 0) begin
            h = q.pop_front();
            gnt = 1; gsrc = 1; popped = 1; ga = h.a; gd = h.d;
        end else if (acc) begin
            gnt = 1; gsrc = 1; ga = mdu_addr; gd = mdu_data;
            acc = 0;
            last_acc = 1;
        end else begin
            last_acc = 0;
        end
        if (acc) begin
            q.push_back('{a: mdu_addr, d: mdu_data});
            last_acc = 1;
        end else if (pipe_we || popped) begin
            last_acc = last_acc && !pipe_we && !popped;
        end
        m_stall = (head_wait >= SM) && !popped;
        if (was_empty || popped) head_wait = 0;
        else if (head_wait < SM) head_wait++;
        e_we = gnt && (ga != 0);
        if (gnt) begin
            e_src = gsrc;
            if (ga != 0) begin
                e_known = 1; e_waddr = ga; e_wdata = gd;
            end else begin
                e_known = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_pipe(input bit we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we; pipe_waddr = a; pipe_wdata = d;
    endtask

    task automatic set_mdu(input bit v, input logic [4:0] a, input logic [31:0] d);
        mdu_valid = v; mdu_addr = a; mdu_data = d;
    endtask

    initial begin
        rst = 1'b1;
        set_pipe(0, 0, 0);
        set_mdu(0, 0, 0);
        last_acc = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_rf_waddr", rf_waddr, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_stall", stall_pipe, 0);
        chk("reset_pend", pend_cnt, 0);
        chk("reset_ready", mdu_ready, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", mdu_ready, 1);

        // Bypass into an empty FIFO
        set_mdu(1, 5, 32'h0000_00AA);
        cycle();
        set_mdu(0, 0, 0);
        chk("bypass_we", rf_we, 1);
        chk("bypass_addr", rf_waddr, 5);
        chk("bypass_data", rf_wdata, 32'hAA);
        chk("bypass_src", rf_src, 1);
        chk("bypass_pend", pend_cnt, 0);
        cycle();
        chk("idle_no_write", rf_we, 0);
        chk("idle_hold_addr", rf_waddr, 5);

        // Pipe priority while the FIFO fills
        for (int i = 0; i < 4; i++) begin
            set_pipe(1, 3, 32'h100 + i);
            if (i == 0) set_mdu(1, 7, 32'h7777);
            else if (i == 1) set_mdu(1, 8, 32'h8888);
            else set_mdu(0, 0, 0);
            cycle();
            chk("fill_pipe_we", rf_we, 1);
            chk("fill_pipe_src", rf_src, 0);
            chk("fill_pipe_data", rf_wdata, 32'h100 + i);
        end
        chk("fill_pend", pend_cnt, 2);
        chk("fill_ready", mdu_ready, 0);
        set_pipe(0, 0, 0);
        cycle();
        chk("drain1_addr", rf_waddr, 7);
        cycle();
        chk("drain2_addr", rf_waddr, 8);
        chk("drain_src", rf_src, 1);
        cycle();

        // Starvation with one pending entry
        set_pipe(1, 2, 32'h2222);
        set_mdu(1, 9, 32'h9999);
        cycle();
        set_mdu(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        chk("starve_stall", stall_pipe, 1);
        chk("starve_pend", pend_cnt, 1);
        set_pipe(0, 0, 0);
        cycle();
        chk("starve_pop_we", rf_we, 1);
        chk("starve_pop_addr", rf_waddr, 9);
        chk("starve_stall_clear", stall_pipe, 0);
        cycle();

        // Register zero from both sources
        set_pipe(1, 0, 32'hDEAD);
        set_mdu(1, 0, 32'hBEEF);
        cycle();
        set_mdu(0, 0, 0);
        chk("zero_pipe_we", rf_we, 0);
        chk("zero_entry_pend", pend_cnt, 1);
        set_pipe(0, 0, 0);
        cycle();
        chk("zero_pop_we", rf_we, 0);
        chk("zero_pop_pend", pend_cnt, 0);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (last_acc) mdu_valid = 0;
            if (!mdu_valid && ($urandom % 3 == 0))
                set_mdu(1, 5'($urandom), $urandom);
            set_pipe(($urandom % 2) == 1, 5'($urandom), $urandom);
            cycle();
        end
        set_mdu(0, 0, 0);

        // Asynchronous reset with a full FIFO
        set_pipe(1, 4, 32'h4444);
        set_mdu(1, 10, 32'hA);
        cycle();
        set_mdu(1, 11, 32'hB);
        cycle();
        set_mdu(0, 0, 0);
        chk("prereset_pend", pend_cnt, 2);
        #2 rst = 1'b1;
        #1;
        chk("async_rf_we", rf_we, 0);
        chk("async_rf_waddr", rf_waddr, 0);
        chk("async_rf_wdata", rf_wdata, 0);
        chk("async_rf_src", rf_src, 0);
        chk("async_stall", stall_pipe, 0);
        chk("async_pend", pend_cnt, 0);
        chk("async_ready", mdu_ready, 0);
        set_pipe(0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("inreset_no_write", rf_we, 0);
        model_reset();
        last_acc = 0;
        rst = 1'b0;
        #1;
        chk("release_ready", mdu_ready, 1);
        cycle();
        chk("no_stale_write", rf_we, 0);
        chk("no_stale_pend", pend_cnt, 0);
        set_pipe(1, 6, 32'h6666);
        cycle();
        set_pipe(0, 0, 0);
        chk("post_reset_grant", rf_wdata, 32'h6666);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
